// File: rtl/demux2_sched_pkg.sv
// demux2_sched_pkg
//   Shared types and constants for the two-way demux steering controller.
//   state_t    : handshake FSM states (IDLE, REQ, RTZ).
//   SEL0, SEL1 : values of the steering bit that select output 0 and output 1.
package demux2_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RTZ  = 2'd2
  } state_t;

  localparam logic SEL0 = 1'b0;
  localparam logic SEL1 = 1'b1;

endpackage

// File: rtl/sync2.sv
// sync2
//   Generic two-flop synchronizer for a single-bit level signal.
//   The output follows the input two clock edges later.
//   Ports:
//     clk : clock
//     rst : synchronous active-high reset, clears both stages
//     d   : asynchronous input level
//     q   : synchronized output level
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back stages give the first flop a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/demux2_sched.sv
// demux2_sched
//   Clocked steering controller for a two-way self-timed demux. It issues a
//   4-phase control token (rctl_o/dctl_o), waits for the acknowledge (actl_i),
//   and chooses output 0 or 1 for each token by weighted round-robin, gated by
//   per-output credit counters that downstream consumers replenish.
//
//   Optional build macro DEMUX2_SCHED_SYNC_ACK_EN: when defined, actl_i passes
//   through a two-flop synchronizer (sync2); otherwise actl_i is used directly
//   and must come from clk-synchronous logic.
//
//   Ports:
//     clk     : clock
//     rst     : synchronous active-high reset
//     en_i    : permits new tokens, sampled only in IDLE
//     rctl_o  : registered control request to the demux
//     dctl_o  : registered steering bit (0 = output 0, 1 = output 1)
//     actl_i  : control acknowledge from the demux
//     cred0_i : one-cycle credit return pulse for output 0
//     cred1_i : one-cycle credit return pulse for output 1
//     cnt0_o  : registered credit count, output 0
//     cnt1_o  : registered credit count, output 1
//     busy_o  : high whenever the FSM is not in IDLE
//     err_o   : sticky credit-overflow flag, cleared only by rst
module demux2_sched
  import demux2_sched_pkg::*;
#(
  parameter int CW    = 4,
  parameter int CRED0 = 4,
  parameter int CRED1 = 4,
  parameter int W0    = 1,
  parameter int W1    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  output logic          rctl_o,
  output logic          dctl_o,
  input  logic          actl_i,
  input  logic          cred0_i,
  input  logic          cred1_i,
  output logic [CW-1:0] cnt0_o,
  output logic [CW-1:0] cnt1_o,
  output logic          busy_o,
  output logic          err_o
);

  // Burst counter must hold the larger of the two weights.
  localparam int WMAX = (W0 > W1) ? W0 : W1;
  localparam int BW   = $clog2(WMAX + 1);

  localparam logic [CW-1:0] CMAX    = {CW{1'b1}};
  localparam logic [CW-1:0] CONE    = CW'(1);
  localparam logic [CW-1:0] CRED0_L = CW'(CRED0);
  localparam logic [CW-1:0] CRED1_L = CW'(CRED1);
  localparam logic [BW-1:0] BONE    = BW'(1);
  localparam logic [BW-1:0] W0_L    = BW'(W0);
  localparam logic [BW-1:0] W1_L    = BW'(W1);

  state_t          state;
  state_t          state_next;
  logic            ack_s;
  logic [CW-1:0]   cnt0;
  logic [CW-1:0]   cnt1;
  logic            pref;
  logic [BW-1:0]   burst;
  logic            err;

  logic            issue;
  logic            side;
  logic            pref_next;
  logic [BW-1:0]   burst_next;
  logic            launch;
  logic            rctl_next;
  logic            dctl_next;
  logic            dec0;
  logic            dec1;

`ifdef DEMUX2_SCHED_SYNC_ACK_EN
  sync2 u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (actl_i),
    .q   (ack_s)
  );
`else
  assign ack_s = actl_i;
`endif

  // Weighted round-robin choice. The preferred side keeps the token until
  // its burst reaches its weight; then the other side is offered. If the
  // other side has no credit, the preferred side starts a fresh burst.
  always_comb begin
    logic          pref_has;
    logic          other_has;
    logic [BW-1:0] pref_w;
    pref_has   = pref ? (cnt1 != '0) : (cnt0 != '0);
    other_has  = pref ? (cnt0 != '0) : (cnt1 != '0);
    pref_w     = pref ? W1_L : W0_L;
    issue      = 1'b0;
    side       = pref;
    pref_next  = pref;
    burst_next = burst;
    if (pref_has && (burst < pref_w)) begin
      issue      = 1'b1;
      side       = pref;
      burst_next = burst + BONE;
    end else if (other_has) begin
      issue      = 1'b1;
      side       = ~pref;
      pref_next  = ~pref;
      burst_next = BONE;
    end else if (pref_has) begin
      issue      = 1'b1;
      side       = pref;
      burst_next = BONE;
    end
  end

  assign launch = (state == IDLE) && en_i && issue;
  assign dec0   = launch && (side == SEL0);
  assign dec1   = launch && (side == SEL1);

  // State register, together with the registered handshake outputs and the
  // round-robin bookkeeping that only advances when a token is launched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rctl_o <= 1'b0;
      dctl_o <= SEL0;
      pref   <= SEL0;
      burst  <= '0;
    end else begin
      state  <= state_next;
      rctl_o <= rctl_next;
      dctl_o <= dctl_next;
      if (launch) begin
        pref  <= pref_next;
        burst <= burst_next;
      end
    end
  end

  // Next-state logic for the 4-phase handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = REQ;
      REQ:     if (ack_s)  state_next = RTZ;
      RTZ:     if (!ack_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: dctl only moves at launch, when rctl and ack are both low,
  // so the steering bit is stable for the whole handshake.
  always_comb begin
    rctl_next = rctl_o;
    dctl_next = dctl_o;
    case (state)
      IDLE: begin
        if (launch) begin
          rctl_next = 1'b1;
          dctl_next = side;
        end
      end
      REQ: begin
        if (ack_s) rctl_next = 1'b0;
      end
      default: begin
        rctl_next = rctl_o;
      end
    endcase
  end

  // Credit counters. A return and an issue on the same edge cancel out.
  // A return into a full counter saturates and raises the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= CRED0_L;
      cnt1 <= CRED1_L;
      err  <= 1'b0;
    end else begin
      if (cred0_i && !dec0) begin
        if (cnt0 == CMAX) err <= 1'b1;
        else              cnt0 <= cnt0 + CONE;
      end else if (dec0 && !cred0_i) begin
        cnt0 <= cnt0 - CONE;
      end
      if (cred1_i && !dec1) begin
        if (cnt1 == CMAX) err <= 1'b1;
        else              cnt1 <= cnt1 + CONE;
      end else if (dec1 && !cred1_i) begin
        cnt1 <= cnt1 - CONE;
      end
    end
  end

  assign cnt0_o = cnt0;
  assign cnt1_o = cnt1;
  assign busy_o = (state != IDLE);
  assign err_o  = err;

endmodule

// File: tb/tb_demux2_sched.sv
// tb_demux2_sched
//   Directed bench for demux2_sched. Three instances share one clock:
//     u_a : defaults (CW=4, 4/4 credits, W0=W1=1) - round-robin, exhaustion,
//           simultaneous issue/return, reset mid-REQ, en_i drop
//     u_b : W0=3, W1=1, 15/15 credits            - weighting
//     u_c : CW=2, CRED0=2, CRED1=0               - starvation, overflow
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_demux2_sched;

  logic       clk;
  logic [2:0] rst;
  logic [2:0] en;
  logic [2:0] actl;
  logic [2:0] cred0;
  logic [2:0] cred1;
  wire  [2:0] rctl;
  wire  [2:0] dctl;
  wire  [2:0] busy;
  wire  [2:0] err;
  wire  [3:0] cnt0_a, cnt1_a, cnt0_b, cnt1_b;
  wire  [1:0] cnt0_c, cnt1_c;

  int checks = 0;
  int errors = 0;

  demux2_sched #(.CW(4), .CRED0(4), .CRED1(4), .W0(1), .W1(1)) u_a (
    .clk(clk), .rst(rst[0]), .en_i(en[0]), .rctl_o(rctl[0]), .dctl_o(dctl[0]),
    .actl_i(actl[0]), .cred0_i(cred0[0]), .cred1_i(cred1[0]),
    .cnt0_o(cnt0_a), .cnt1_o(cnt1_a), .busy_o(busy[0]), .err_o(err[0])
  );

  demux2_sched #(.CW(4), .CRED0(15), .CRED1(15), .W0(3), .W1(1)) u_b (
    .clk(clk), .rst(rst[1]), .en_i(en[1]), .rctl_o(rctl[1]), .dctl_o(dctl[1]),
    .actl_i(actl[1]), .cred0_i(cred0[1]), .cred1_i(cred1[1]),
    .cnt0_o(cnt0_b), .cnt1_o(cnt1_b), .busy_o(busy[1]), .err_o(err[1])
  );

  demux2_sched #(.CW(2), .CRED0(2), .CRED1(0), .W0(1), .W1(1)) u_c (
    .clk(clk), .rst(rst[2]), .en_i(en[2]), .rctl_o(rctl[2]), .dctl_o(dctl[2]),
    .actl_i(actl[2]), .cred0_i(cred0[2]), .cred1_i(cred1[2]),
    .cnt0_o(cnt0_c), .cnt1_o(cnt1_c), .busy_o(busy[2]), .err_o(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_val(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Wait (bounded) for a request on instance idx, check its steering bit,
  // then acknowledge for one cycle and release. Returns with the FSM in IDLE.
  task automatic apply_token(input int idx, input logic side, input int budget, input string tag);
    int k = 0;
    while (rctl[idx] !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_bit({tag, "_req"}, rctl[idx], 1'b1);
    if (rctl[idx] === 1'b1) begin
      check_bit({tag, "_side"}, dctl[idx], side);
      actl[idx] = 1'b1;
      @(negedge clk);
      check_bit({tag, "_rtz"}, rctl[idx], 1'b0);
      actl[idx] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst   = 3'b111;
    en    = 3'b000;
    actl  = 3'b000;
    cred0 = 3'b000;
    cred1 = 3'b000;
    repeat (2) @(negedge clk);
    rst = 3'b000;

    // Reset state of every instance.
    check_bit("rst_rctl_a", rctl[0], 1'b0);
    check_bit("rst_dctl_a", dctl[0], 1'b0);
    check_bit("rst_busy_a", busy[0], 1'b0);
    check_bit("rst_err_a", err[0], 1'b0);
    check_val("rst_cnt0_a", cnt0_a, 4'd4);
    check_val("rst_cnt1_a", cnt1_a, 4'd4);
    check_val("rst_cnt0_b", cnt0_b, 4'd15);
    check_val("rst_cnt0_c", {2'b00, cnt0_c}, 4'd2);
    check_val("rst_cnt1_c", {2'b00, cnt1_c}, 4'd0);

    // Round-robin alternation until both counters run dry.
    $display("[TB] round-robin and exhaustion");
    en[0] = 1'b1;
    for (int t = 0; t < 8; t++) apply_token(0, t[0], 20, "rr");
    repeat (6) begin
      @(negedge clk);
      check_bit("rr_idle_rctl", rctl[0], 1'b0);
    end
    check_bit("rr_idle_busy", busy[0], 1'b0);
    check_val("rr_cnt0", cnt0_a, 4'd0);
    check_val("rr_cnt1", cnt1_a, 4'd0);

    // Bring cnt0 to 2, then return a side-0 credit on the issuing edge.
    $display("[TB] simultaneous issue and return");
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check_val("rst2_cnt0", cnt0_a, 4'd4);
    for (int t = 0; t < 4; t++) apply_token(0, t[0], 20, "sim_pre");
    en[0] = 1'b0;
    @(negedge clk);
    check_val("sim_pre_cnt0", cnt0_a, 4'd2);
    check_val("sim_pre_cnt1", cnt1_a, 4'd2);
    en[0]    = 1'b1;
    cred0[0] = 1'b1;
    @(negedge clk);
    cred0[0] = 1'b0;
    en[0]    = 1'b0;
    check_bit("sim_rctl", rctl[0], 1'b1);
    check_bit("sim_dctl", dctl[0], 1'b0);
    check_val("sim_cnt0", cnt0_a, 4'd2);
    actl[0] = 1'b1;
    @(negedge clk);
    actl[0] = 1'b0;
    @(negedge clk);
    check_val("sim_cnt0_after", cnt0_a, 4'd2);
    check_bit("sim_busy_after", busy[0], 1'b0);

    // Reset while a request is outstanding.
    $display("[TB] reset mid-REQ");
    en[0] = 1'b1;
    @(negedge clk);
    check_bit("rreq_rctl", rctl[0], 1'b1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    en[0]  = 1'b0;
    check_bit("rreq_rctl_after", rctl[0], 1'b0);
    check_bit("rreq_busy_after", busy[0], 1'b0);
    check_bit("rreq_dctl_after", dctl[0], 1'b0);
    check_val("rreq_cnt0", cnt0_a, 4'd4);
    check_val("rreq_cnt1", cnt1_a, 4'd4);

    // en_i drop during REQ: handshake completes, no further token.
    $display("[TB] en drop during REQ");
    en[0] = 1'b1;
    @(negedge clk);
    check_bit("endrop_rctl", rctl[0], 1'b1);
    check_bit("endrop_dctl", dctl[0], 1'b0);
    en[0]   = 1'b0;
    actl[0] = 1'b1;
    @(negedge clk);
    check_bit("endrop_rtz_rctl", rctl[0], 1'b0);
    check_bit("endrop_rtz_busy", busy[0], 1'b1);
    actl[0] = 1'b0;
    @(negedge clk);
    check_bit("endrop_idle_busy", busy[0], 1'b0);
    repeat (4) begin
      @(negedge clk);
      check_bit("endrop_no_token", rctl[0], 1'b0);
    end
    check_val("endrop_cnt0", cnt0_a, 4'd3);

    // Weighted round-robin: three tokens to output 0 per token to output 1.
    $display("[TB] weighting W0=3 W1=1");
    en[1] = 1'b1;
    for (int t = 0; t < 12; t++) apply_token(1, (t % 4) == 3, 20, "wrr");
    en[1] = 1'b0;
    check_val("wrr_cnt0", cnt0_b, 4'd6);
    check_val("wrr_cnt1", cnt1_b, 4'd12);

    // Starvation: output 1 has no credit, so output 0 takes both tokens.
    $display("[TB] credit starvation");
    en[2] = 1'b1;
    apply_token(2, 1'b0, 20, "starve0");
    apply_token(2, 1'b0, 20, "starve1");
    repeat (4) begin
      @(negedge clk);
      check_bit("starve_idle_rctl", rctl[2], 1'b0);
    end
    check_val("starve_cnt0", {2'b00, cnt0_c}, 4'd0);
    cred1[2] = 1'b1;
    @(negedge clk);
    cred1[2] = 1'b0;
    apply_token(2, 1'b1, 2, "starve_ret");
    en[2] = 1'b0;
    check_val("starve_cnt1", {2'b00, cnt1_c}, 4'd0);

    // Overflow on a 2-bit counter: fill to 3, then one more return.
    $display("[TB] credit overflow");
    cred0[2] = 1'b1;
    repeat (3) @(negedge clk);
    cred0[2] = 1'b0;
    check_val("ovf_fill_cnt0", {2'b00, cnt0_c}, 4'd3);
    check_bit("ovf_fill_err", err[2], 1'b0);
    cred0[2] = 1'b1;
    @(negedge clk);
    cred0[2] = 1'b0;
    check_val("ovf_cnt0", {2'b00, cnt0_c}, 4'd3);
    check_bit("ovf_err", err[2], 1'b1);
    repeat (3) @(negedge clk);
    check_bit("ovf_err_sticky", err[2], 1'b1);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    check_bit("ovf_err_cleared", err[2], 1'b0);
    check_val("ovf_rst_cnt0", {2'b00, cnt0_c}, 4'd2);
    check_val("ovf_rst_cnt1", {2'b00, cnt1_c}, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux2_sched.md
Name: demux2_sched

Overview:
- Clocked steering controller for the two-way demux control channel: produces the 4-phase control token (rctl/dctl) and consumes its acknowledge (actl).
- Chooses output 0 or 1 per token by weighted round-robin, gated by per-output credit counters replenished by downstream consumers.
- Sits between the clocked configuration/flow-control domain and the self-timed demux; one token steers exactly one data transfer.

Parameters:
- CW, 4: credit counter width; max credits 2^CW-1.
- CRED0, 4: credits loaded for output 0 at reset; must be <= 2^CW-1.
- CRED1, 4: credits loaded for output 1 at reset; must be <= 2^CW-1.
- W0, 1: max consecutive tokens to output 0 before offering output 1; >= 1.
- W1, 1: max consecutive tokens to output 1 before offering output 0; >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high. Fixed polarity, no polarity parameter.
- en_i  in  1  permits starting new tokens; sampled only in IDLE.
- rctl_o  out  1  control request to demux, registered.
- dctl_o  out  1  steering bit, registered: 0 selects output 0, 1 selects output 1.
- actl_i  in  1  control acknowledge from demux.
- cred0_i  in  1  one-cycle pulse returning one credit to output 0.
- cred1_i  in  1  one-cycle pulse returning one credit to output 1.
- cnt0_o  out  CW  current credits, output 0.
- cnt1_o  out  CW  current credits, output 1.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  sticky credit-overflow flag.

Behaviour:
- Reset (any state, next edge):
  - rctl_o=0, dctl_o=0, busy_o=0, err_o=0.
  - cnt0=CRED0, cnt1=CRED1, pref=0, burst=0, state=IDLE.
  - Reset mid-handshake abandons the token; the system must reset the demux in the same window.
- FSM states: IDLE, REQ, RTZ.
- IDLE, en_i=1, selection in priority order:
  - (a) pref has credit and burst<W[pref]: choose pref, burst+1.
  - (b) else other side has credit: choose other, pref=other, burst=1.
  - (c) else pref has credit: choose pref, burst=1.
  - (d) else stay IDLE.
  - On choosing: next edge sets dctl_o=side, rctl_o=1, decrements cnt[side], and moves to REQ.
- REQ: hold rctl_o=1 and dctl_o stable. When ack_s=1, next edge sets rctl_o=0 and moves to RTZ.
- RTZ: hold dctl_o stable. When ack_s=0, next edge moves to IDLE.
  - dctl_o never changes while rctl_o=1 or ack_s=1.
- ack_s is the synchronized actl_i (see Optional Feature).
- Minimum token period: 4 cycles with direct ack and an immediate demux, i.e. IDLE→REQ→RTZ→IDLE plus ack turnaround.
- en_i deasserted in REQ/RTZ: the handshake completes; no new token starts.
- Credits:
  - A cred pulse increments its counter.
  - Simultaneous return and issue on the same side: net unchanged.
  - Return when the counter = 2^CW-1: counter saturates and err_o sets; err_o clears only on rst.
- Both counters 0: IDLE waits. The first returned credit is usable on the edge after its pulse (registered count).
- cnt0_o/cnt1_o reflect the registered counts.

Optional Feature:
- Macro: DEMUX2_SCHED_SYNC_ACK_EN.
- Defined: actl_i passes through a 2-flop synchronizer; ack_s lags actl_i by 2 cycles. Minimum token period is 8 cycles with an immediate demux.
- Undefined: ack_s=actl_i combinationally. actl_i must be generated from clk-synchronous logic.

Decomposition:
- Package demux2_sched_pkg holds:
  - state_t enum {IDLE, REQ, RTZ};
  - SEL0=1'b0 and SEL1=1'b1 side constants.
- Sub-module sync2: generic 2-flop synchronizer, instantiated only under DEMUX2_SCHED_SYNC_ACK_EN.
- Credit counters, selection logic and FSM stay in demux2_sched.

Test Plan:
- Round-robin and credit exhaustion:
  - Stimulus: W0=W1=1, CRED0=CRED1=4, en_i=1, bench acks each rctl_o after 1 cycle, no returns.
  - Required: dctl sequence 0,1,0,1,0,1,0,1, then rctl_o stays 0; cnt0=cnt1=0.
- Weighting:
  - Stimulus: W0=3, W1=1, ample credits.
  - Required: dctl pattern 0,0,0,1 repeating over 12 tokens.
- Credit starvation:
  - Stimulus: CRED1=0, CRED0=2.
  - Required: tokens 0,0, then idle. A cred1_i pulse issues one token with dctl=1 within 2 cycles.
- Simultaneous issue and return:
  - Stimulus: cred0_i pulses on the edge that issues a side-0 token, cnt0=2.
  - Required: cnt0 remains 2.
- Overflow:
  - Stimulus: CW=2, cnt0=3, cred0_i pulse.
  - Required: cnt0 stays 3; err_o=1 until rst.
- Reset mid-REQ and en_i drop:
  - Stimulus: rst asserted while rctl_o=1.
  - Required: next cycle rctl_o=0, cnts=CRED0/CRED1, IDLE.
  - Stimulus: en_i=0 during REQ.
  - Required: handshake completes through RTZ; no new rctl_o.
